// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester A/B handshakes plus byte-wide memory bus
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              a_req, a_we, a_ack;
  logic [1:0]        a_size;
  logic [ADDR_W-1:0] a_address;
  logic [31:0]       a_wdata, a_rdata;
  logic              b_req, b_we, b_ack;
  logic [1:0]        b_size;
  logic [ADDR_W-1:0] b_address;
  logic [31:0]       b_wdata, b_rdata;
  logic [ADDR_W-1:0] address;
  logic [7:0]        i_data, o_data;
  logic              we;
  modport slave (
    input  a_req, a_we, a_size, a_address, a_wdata,
    input  b_req, b_we, b_size, b_address, b_wdata, i_data,
    output a_rdata, a_ack, b_rdata, b_ack, address, o_data, we
  );
  modport master (
    output a_req, a_we, a_size, a_address, a_wdata,
    output b_req, b_we, b_size, b_address, b_wdata, i_data,
    input  a_rdata, a_ack, b_rdata, b_ack, address, o_data, we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer for a byte-wide memory; MEM_ARB_RR_EN selects round-robin arbitration
module mem_arbiter #(parameter int ADDR_W = 32) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;
  state_t            state;
  logic              sel_b, wr, grant_b, g_we;
  logic [2:0]        cnt, n, g_n;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] base, g_addr;
  logic [31:0]       data, g_wdata, rd_val;
`ifdef MEM_ARB_RR_EN
  logic              last_a;
  assign grant_b = bus.b_req && (!bus.a_req || last_a);
`else
  assign grant_b = bus.b_req && !bus.a_req;
`endif
  assign g_we    = grant_b ? bus.b_we : bus.a_we;
  assign g_size  = grant_b ? bus.b_size : bus.a_size;
  assign g_addr  = grant_b ? bus.b_address : bus.a_address;
  assign g_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
  assign g_n     = (g_size == 2'd0) ? 3'd1 : (g_size == 2'd1) ? 3'd2 : 3'd4;
  assign rd_val  = data | (32'(bus.i_data) << {n - 3'd1, 3'd0});
  // Grant, byte sequencing and completion; the first byte is driven on the grant edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bus.address <= '0;
      bus.o_data  <= '0;
      bus.we      <= 1'b0;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
      sel_b       <= 1'b0;
      wr          <= 1'b0;
      cnt         <= '0;
      n           <= '0;
      base        <= '0;
      data        <= '0;
`ifdef MEM_ARB_RR_EN
      last_a      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.a_req || bus.b_req) begin
          sel_b       <= grant_b;
          wr          <= g_we;
          n           <= g_n;
          base        <= g_addr;
          data        <= g_we ? g_wdata : 32'h0;
          bus.address <= g_addr;
          bus.we      <= g_we;
          bus.o_data  <= g_we ? g_wdata[7:0] : 8'h00;
          cnt         <= 3'd1;
          state       <= XFER;
`ifdef MEM_ARB_RR_EN
          last_a      <= !grant_b;
`endif
        end
        XFER: begin
          if (!wr && cnt >= 3'd2) data[{cnt - 3'd2, 3'd0} +: 8] <= bus.i_data;
          if (cnt == n) begin
            bus.we     <= 1'b0;
            bus.o_data <= 8'h00;
            state      <= wr ? DONE : TAIL;
            bus.a_ack  <= wr && !sel_b;
            bus.b_ack  <= wr && sel_b;
          end else begin
            bus.address <= base + ADDR_W'(cnt);
            bus.o_data  <= wr ? data[{cnt, 3'd0} +: 8] : 8'h00;
            cnt         <= cnt + 3'd1;
          end
        end
        TAIL: begin
          if (sel_b) bus.b_rdata <= rd_val;
          else bus.a_rdata <= rd_val;
          bus.a_ack <= !sel_b;
          bus.b_ack <= sel_b;
          state     <= DONE;
        end
        DONE: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks against a transaction-level model of the arbiter and memory
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  mem_arbiter_if bus();
  mem_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
  logic [7:0] mem [bit [19:0]];
  logic [7:0] ref_mem [bit [19:0]];
  bit last_b = 1'b1;
  logic [31:0] model_rd [2] = '{32'h0, 32'h0};
  bit rd_known [2] = '{1'b1, 1'b1};

  function automatic logic [7:0] mget(input logic [19:0] k);
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  function automatic logic [7:0] rget(input logic [19:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  // Memory with one cycle of read latency
  always @(posedge clock) begin
    bus.i_data <= mget(bus.address[19:0]);
    if (bus.we) mem[bus.address[19:0]] = bus.o_data;
  end

  function automatic bit model_pick_b(input bit a, input bit b);
`ifdef MEM_ARB_RR_EN
    return b && (!a || !last_b);
`else
    return b && !a;
`endif
  endfunction

  task automatic set_req(input bit pb, input bit w, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    if (pb) begin
      bus.b_we = w; bus.b_size = sz; bus.b_address = ad; bus.b_wdata = wd; bus.b_req = 1'b1;
    end else begin
      bus.a_we = w; bus.a_size = sz; bus.a_address = ad; bus.a_wdata = wd; bus.a_req = 1'b1;
    end
  endtask

  task automatic wait_txn(input bit exp_b, output bit got_b);
    logic w;
    logic [1:0] sz;
    logic [31:0] base, wd, exp_rd, got_rd, other_rd;
    int n, exp_c, ack_c;
    w    = exp_b ? bus.b_we : bus.a_we;
    sz   = exp_b ? bus.b_size : bus.a_size;
    base = exp_b ? bus.b_address : bus.a_address;
    wd   = exp_b ? bus.b_wdata : bus.a_wdata;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_c = w ? n + 1 : n + 2;
    exp_rd = 32'h0;
    for (int i = 0; i < n; i++) exp_rd |= 32'(rget(20'(base + 32'(i)))) << (8 * i);
    ack_c = 0;
    got_b = 1'b0;
    for (int c = 1; c <= 12 && ack_c == 0; c++) begin
      @(negedge clock);
      if (bus.a_ack || bus.b_ack) begin
        ack_c = c;
        got_b = bus.b_ack;
        total++;
        if ({bus.a_ack, bus.b_ack} !== (exp_b ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL ack_port got=%b exp=%b", {bus.a_ack, bus.b_ack}, exp_b ? 2'b01 : 2'b10);
        end
        total++;
        if (bus.we !== 1'b0) begin bad++; $display("FAIL we_at_ack got=%b exp=0", bus.we); end
      end else if (c <= n) begin
        total++;
        if (bus.address !== base + 32'(c - 1)) begin
          bad++; $display("FAIL addr cyc%0d got=%h exp=%h", c, bus.address, base + 32'(c - 1));
        end
        total++;
        if (bus.we !== w) begin bad++; $display("FAIL we cyc%0d got=%b exp=%b", c, bus.we, w); end
        total++;
        if (bus.o_data !== (w ? wd[8*(c-1) +: 8] : 8'h00)) begin
          bad++; $display("FAIL o_data cyc%0d got=%h exp=%h", c, bus.o_data, w ? wd[8*(c-1) +: 8] : 8'h00);
        end
      end else begin
        total++;
        if (bus.we !== 1'b0) begin bad++; $display("FAIL we_tail cyc%0d got=%b exp=0", c, bus.we); end
      end
    end
    total++;
    if (ack_c != exp_c) begin bad++; $display("FAIL ack_cycle got=%0d exp=%0d", ack_c, exp_c); end
    got_rd   = exp_b ? bus.b_rdata : bus.a_rdata;
    other_rd = exp_b ? bus.a_rdata : bus.b_rdata;
    if (rd_known[!exp_b]) begin
      total++;
      if (other_rd !== model_rd[!exp_b]) begin bad++; $display("FAIL loser_rdata got=%h exp=%h", other_rd, model_rd[!exp_b]); end
    end
    if (!w) begin
      total++;
      if (got_rd !== exp_rd) begin bad++; $display("FAIL rdata got=%h exp=%h", got_rd, exp_rd); end
      model_rd[exp_b] = exp_rd;
      rd_known[exp_b] = 1'b1;
    end else begin
      rd_known[exp_b] = 1'b0;
      for (int i = 0; i < n; i++) begin
        ref_mem[20'(base + 32'(i))] = wd[8*i +: 8];
        total++;
        if (mget(20'(base + 32'(i))) !== wd[8*i +: 8]) begin
          bad++; $display("FAIL mem_byte%0d got=%h exp=%h", i, mget(20'(base + 32'(i))), wd[8*i +: 8]);
        end
      end
    end
    last_b = exp_b;
    if (exp_b) bus.b_req = 1'b0;
    else bus.a_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if (bus.address !== 32'h0 || bus.o_data !== 8'h00 || bus.we !== 1'b0) begin
      bad++; $display("FAIL reset_mem got=%h/%h/%b exp=0/0/0", bus.address, bus.o_data, bus.we);
    end
    total++;
    if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0) begin
      bad++; $display("FAIL reset_ack got=%b%b exp=00", bus.a_ack, bus.b_ack);
    end
    total++;
    if (bus.a_rdata !== 32'h0 || bus.b_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.a_rdata, bus.b_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_dword_write();
    bit g;
    set_req(1'b0, 1'b1, 2'd2, 32'h100, 32'h11223344);
    wait_txn(1'b0, g);
    total++;
    if ({mget(20'h103), mget(20'h102), mget(20'h101), mget(20'h100)} !== 32'h11223344) begin
      bad++; $display("FAIL dword_mem got=%h exp=11223344", {mget(20'h103), mget(20'h102), mget(20'h101), mget(20'h100)});
    end
  endtask

  task automatic test_read();
    bit g;
    set_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    wait_txn(1'b0, g);
    total++;
    if (bus.a_rdata !== 32'h11223344) begin bad++; $display("FAIL a_read got=%h exp=11223344", bus.a_rdata); end
    set_req(1'b1, 1'b0, 2'd0, 32'h102, 32'h0);
    wait_txn(1'b1, g);
    total++;
    if (bus.b_rdata !== 32'h22) begin bad++; $display("FAIL b_read got=%h exp=00000022", bus.b_rdata); end
    total++;
    if (bus.a_rdata !== 32'h11223344) begin bad++; $display("FAIL a_hold got=%h exp=11223344", bus.a_rdata); end
  endtask

  task automatic test_priority();
    bit g, e;
    logic [3:0] order;
`ifdef MEM_ARB_RR_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    set_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    set_req(1'b1, 1'b0, 2'd1, 32'h102, 32'h0);
    for (int k = 0; k < 4; k++) begin
      e = model_pick_b(bus.a_req, bus.b_req);
      wait_txn(e, g);
      total++;
      if (g !== order[k]) begin bad++; $display("FAIL grant%0d got=%b exp=%b", k, g, order[k]); end
      if (k < 3) begin
        if (g) set_req(1'b1, 1'b0, 2'd1, 32'h102, 32'h0);
        else set_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
      end
    end
    for (int k = 0; k < 2 && (bus.a_req || bus.b_req); k++) wait_txn(model_pick_b(bus.a_req, bus.b_req), g);
  endtask

  task automatic test_wrap();
    bit g;
    set_req(1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h0000BEEF);
    wait_txn(1'b0, g);
    total++;
    if (mget(20'hFFFFF) !== 8'hEF || mget(20'h00000) !== 8'hBE) begin
      bad++; $display("FAIL wrap_mem got=%h%h exp=beef", mget(20'h00000), mget(20'hFFFFF));
    end
  endtask

  task automatic test_reset_abort();
    bit g;
    int acks;
    set_req(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus.a_req = 1'b0;
    @(negedge clock);
    total++;
    if (bus.we !== 1'b0 || bus.a_ack !== 1'b0 || bus.a_rdata !== 32'h0) begin
      bad++; $display("FAIL abort_state got=%b/%b/%h exp=0/0/0", bus.we, bus.a_ack, bus.a_rdata);
    end
    reset = 1'b0;
    last_b = 1'b1;
    model_rd[0] = 32'h0; model_rd[1] = 32'h0;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.a_ack || bus.b_ack) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL abort_ack got=%0d exp=0", acks); end
    set_req(1'b1, 1'b0, 2'd0, 32'h103, 32'h0);
    wait_txn(1'b1, g);
    total++;
    if (bus.b_rdata !== 32'h11) begin bad++; $display("FAIL abort_bread got=%h exp=00000011", bus.b_rdata); end
  endtask

  task automatic test_random();
    bit g, first, use_a, use_b;
    int mode;
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 2);
      use_a = (mode != 1);
      use_b = (mode != 0);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && use_a) || (p == 1 && use_b))
          set_req(p[0], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : 32'h200 + $urandom_range(0, 63),
                  $urandom);
      end
      first = model_pick_b(bus.a_req, bus.b_req);
      wait_txn(first, g);
      if (use_a && use_b) wait_txn(!first, g);
    end
  endtask

  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_size = 2'd0; bus.a_address = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_size = 2'd0; bus.b_address = '0; bus.b_wdata = '0;
    test_reset();
    test_dword_write();
    test_read();
    test_priority();
    test_wrap();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
